issueque_int: RTL and testbench

Integer issue queue directly downstream of `dispatch`. Four-entry reservation queue that:
- accepts decoded integer instructions through the `equeue_*` / `equeueint_*` handshake;
- snoops the CDB to capture operands that are still pending;
- presents the oldest entry with both operands valid to the integer issue arbiter.

---
 rtl/issueque_pkg.sv | 45 ++++
 rtl/issueque_slot.sv | 36 +++
 rtl/issueque_int.sv | 139 +++++++++++++
 tb/tb_issueque_int.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issueque_pkg.sv
// Shared types for the integer issue queue.
// Entry layout plus the CDB capture rule used by slots and enqueue.
package issueque_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int IQ_TAG_W = 6;
  localparam int OPC_W    = 3;
  localparam int DATA_W   = 32;
  localparam int IMM_W    = 16;

  typedef struct packed {
    logic                valid;
    logic [OPC_W-1:0]    opcode;
    logic [IQ_TAG_W-1:0] rdtag;
    logic [IQ_TAG_W-1:0] rstag;
    logic [DATA_W-1:0]   rsdata;
    logic                rsvalid;
    logic [IQ_TAG_W-1:0] rttag;
    logic [DATA_W-1:0]   rtdata;
    logic                rtvalid;
    logic [IMM_W-1:0]    imm;
  } issueque_entry_t;

  function automatic issueque_entry_t iq_snoop(
    input issueque_entry_t     e,
    input logic                cv,
    input logic [IQ_TAG_W-1:0] ct,
    input logic [DATA_W-1:0]   cd
  );
    issueque_entry_t r;
    r = e;
    if (e.valid && cv) begin
      if (!e.rsvalid && (e.rstag == ct)) begin
        r.rsvalid = 1'b1;
        r.rsdata  = cd;
      end
      if (!e.rtvalid && (e.rttag == ct)) begin
        r.rtvalid = 1'b1;
        r.rtdata  = cd;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/issueque_slot.sv
// One issue-queue entry: storage plus its CDB tag compare.
// snp_o is the entry with this cycle's broadcast folded in.
module issueque_slot
  import issueque_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                cdb_valid_i,
  input  logic [IQ_TAG_W-1:0] cdb_tag_i,
  input  logic [DATA_W-1:0]   cdb_data_i,
  input  issueque_entry_t     ent_d,
  output issueque_entry_t     snp_o,
  output logic                rdy_o
);

  issueque_entry_t ent_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= '0;
    end else if (flush_i) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign rdy_o = ent_q.valid
               & ent_q.rsvalid
               & ent_q.rtvalid;

  assign snp_o = iq_snoop(ent_q, cdb_valid_i,
                          cdb_tag_i, cdb_data_i);

endmodule

// File: rtl/issueque_int.sv
// Integer issue queue: age-ordered, compacting, CDB snooping.
// Presents the oldest entry whose operands are both available.
module issueque_int
  import issueque_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int TAG_W = IQ_TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IMM_W-1:0]  equeue_imm,
  input  logic [TAG_W-1:0]  equeue_rdtag,
  input  logic [TAG_W-1:0]  equeue_rstag,
  input  logic [TAG_W-1:0]  equeue_rttag,
  input  logic [DATA_W-1:0] equeue_rsdata,
  input  logic [DATA_W-1:0] equeue_rtdata,
  input  logic              equeue_rsvalid,
  input  logic              equeue_rtvalid,
  input  logic [OPC_W-1:0]  equeueint_opcode,
  input  logic              equeueint_en,
  output logic              equeueint_ready,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              cdb_valid,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              issueint_valid,
  output logic [OPC_W-1:0]  issueint_opcode,
  output logic [DATA_W-1:0] issueint_rsdata,
  output logic [DATA_W-1:0] issueint_rtdata,
  output logic [IMM_W-1:0]  issueint_imm,
  output logic [TAG_W-1:0]  issueint_rdtag,
  input  logic              issueint_grant
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]   count_q, count_d, wpos;
  logic            run_q;
  logic            found, issue, enq;
  logic [IW-1:0]   sel;
  logic            rdy [DEPTH];
  issueque_entry_t snp [DEPTH];
  issueque_entry_t nxt [DEPTH];
  issueque_entry_t inc_raw, inc;

  // ready stays low until the first edge out of reset
  assign equeueint_ready = run_q
                         & (count_q < CW'(DEPTH));

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign issue = found & issueint_grant;
  assign enq   = equeueint_en & equeueint_ready;
  assign wpos  = count_q - CW'(issue);

  always_comb begin
    inc_raw         = '0;
    inc_raw.valid   = 1'b1;
    inc_raw.opcode  = equeueint_opcode;
    inc_raw.rdtag   = equeue_rdtag;
    inc_raw.rstag   = equeue_rstag;
    inc_raw.rsdata  = equeue_rsdata;
    inc_raw.rsvalid = equeue_rsvalid;
    inc_raw.rttag   = equeue_rttag;
    inc_raw.rtdata  = equeue_rtdata;
    inc_raw.rtvalid = equeue_rtvalid;
    inc_raw.imm     = equeue_imm;
  end

  assign inc = iq_snoop(inc_raw, cdb_valid,
                        cdb_tag, cdb_data);

  // shift uses snooped entries so captures move with them
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int j;
      j = (issue && (i >= int'(sel))) ? i + 1 : i;
      nxt[i] = (j < DEPTH) ? snp[j] : '0;
      if (enq && (i == int'(wpos))) begin
        nxt[i] = inc;
      end
    end
  end

  always_comb begin
    count_d = count_q - CW'(issue) + CW'(enq);
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    issueque_slot u_slot (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_data_i  (cdb_data),
      .ent_d       (nxt[g]),
      .snp_o       (snp[g]),
      .rdy_o       (rdy[g])
    );
  end

  // a ready entry has no pending source, so snp equals stored state
  assign issueint_valid  = found;
  assign issueint_opcode = found ? snp[sel].opcode : '0;
  assign issueint_rsdata = found ? snp[sel].rsdata : '0;
  assign issueint_rtdata = found ? snp[sel].rtdata : '0;
  assign issueint_imm    = found ? snp[sel].imm    : '0;
  assign issueint_rdtag  = found ? snp[sel].rdtag  : '0;

  a_enq_ready : assert property (
    @(posedge clk) disable iff (!reset)
    !(equeueint_en && !equeueint_ready)
  ) else $error("issueque_int: enqueue while not ready");

endmodule

// File: tb/tb_issueque_int.sv
// Bench for issueque_int: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_issueque_int;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] equeue_imm;
  logic [5:0]  equeue_rdtag, equeue_rstag, equeue_rttag;
  logic [31:0] equeue_rsdata, equeue_rtdata;
  logic        equeue_rsvalid, equeue_rtvalid;
  logic [2:0]  equeueint_opcode;
  logic        equeueint_en, equeueint_ready;
  logic [5:0]  cdb_tag;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic        flush;
  logic        issueint_valid;
  logic [2:0]  issueint_opcode;
  logic [31:0] issueint_rsdata, issueint_rtdata;
  logic [15:0] issueint_imm;
  logic [5:0]  issueint_rdtag;
  logic        issueint_grant;

  always #5 clk = ~clk;

  issueque_int dut (
    .clk              (clk),
    .reset            (reset),
    .equeue_imm       (equeue_imm),
    .equeue_rdtag     (equeue_rdtag),
    .equeue_rstag     (equeue_rstag),
    .equeue_rttag     (equeue_rttag),
    .equeue_rsdata    (equeue_rsdata),
    .equeue_rtdata    (equeue_rtdata),
    .equeue_rsvalid   (equeue_rsvalid),
    .equeue_rtvalid   (equeue_rtvalid),
    .equeueint_opcode (equeueint_opcode),
    .equeueint_en     (equeueint_en),
    .equeueint_ready  (equeueint_ready),
    .cdb_tag          (cdb_tag),
    .cdb_valid        (cdb_valid),
    .cdb_data         (cdb_data),
    .flush            (flush),
    .issueint_valid   (issueint_valid),
    .issueint_opcode  (issueint_opcode),
    .issueint_rsdata  (issueint_rsdata),
    .issueint_rtdata  (issueint_rtdata),
    .issueint_imm     (issueint_imm),
    .issueint_rdtag   (issueint_rdtag),
    .issueint_grant   (issueint_grant)
  );

  typedef struct {
    logic [2:0]  opc;
    logic [5:0]  rd, rst, rtt;
    logic [31:0] rsd, rtd;
    logic        rsv, rtv;
    logic [15:0] imm;
  } m_t;

  typedef struct {
    bit en; bit rsv; bit rtv;
    logic [5:0] rst; logic [5:0] rtt; logic [5:0] rd;
    logic [31:0] rsd; logic [31:0] rtd;
    bit cv; logic [5:0] ct; logic [31:0] cd;
    bit gnt; bit ev;
    logic [5:0] erd; logic [31:0] ers; logic [31:0] ert;
  } vec_t;

  m_t   mq[$];
  bit   m_run;
  int   total, passed;
  vec_t vt [11];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp);
  endtask

  function automatic bit m_ready();
    return m_run && (mq.size() < D);
  endfunction

  task automatic idle();
    equeueint_en     = 1'b0;
    equeue_rsvalid   = 1'b0;
    equeue_rtvalid   = 1'b0;
    equeue_rstag     = '0;
    equeue_rttag     = '0;
    equeue_rdtag     = '0;
    equeue_rsdata    = '0;
    equeue_rtdata    = '0;
    equeue_imm       = '0;
    equeueint_opcode = '0;
    cdb_valid        = 1'b0;
    cdb_tag          = '0;
    cdb_data         = '0;
    issueint_grant   = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic put(input logic [2:0] opc,
                     input logic rsv, input logic rtv,
                     input logic [5:0] rst,
                     input logic [5:0] rtt,
                     input logic [5:0] rd,
                     input logic [31:0] rsd,
                     input logic [31:0] rtd);
    equeueint_en     = 1'b1;
    equeueint_opcode = opc;
    equeue_rsvalid   = rsv;
    equeue_rtvalid   = rtv;
    equeue_rstag     = rst;
    equeue_rttag     = rtt;
    equeue_rdtag     = rd;
    equeue_rsdata    = rsd;
    equeue_rtdata    = rtd;
    equeue_imm       = {10'h2A5, rd};
  endtask

  task automatic bcast(input logic [5:0] t,
                       input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  // compare DUT to model, then advance model and clock together
  task automatic tick();
    int s;
    bit rdy;
    m_t n;
    logic [88:0] eo;
    s = -1;
    rdy = m_ready();
    foreach (mq[i])
      if (s < 0 && mq[i].rsv && mq[i].rtv) s = i;
    eo = '0;
    if (s >= 0)
      eo = {mq[s].opc, mq[s].rsd, mq[s].rtd,
            mq[s].imm, mq[s].rd};
    chk("ready", equeueint_ready, rdy);
    chk("valid", issueint_valid, s >= 0);
    chk("fields", {issueint_opcode, issueint_rsdata,
                   issueint_rtdata, issueint_imm,
                   issueint_rdtag}, eo);
    if (flush) begin
      mq.delete();
    end else begin
      if (s >= 0 && issueint_grant) mq.delete(s);
      foreach (mq[i]) begin
        if (cdb_valid && !mq[i].rsv &&
            mq[i].rst == cdb_tag) begin
          mq[i].rsv = 1'b1;
          mq[i].rsd = cdb_data;
        end
        if (cdb_valid && !mq[i].rtv &&
            mq[i].rtt == cdb_tag) begin
          mq[i].rtv = 1'b1;
          mq[i].rtd = cdb_data;
        end
      end
      if (equeueint_en && rdy) begin
        n.opc = equeueint_opcode;
        n.rd  = equeue_rdtag;
        n.rst = equeue_rstag;
        n.rtt = equeue_rttag;
        n.rsd = equeue_rsdata;
        n.rtd = equeue_rtdata;
        n.rsv = equeue_rsvalid;
        n.rtv = equeue_rtvalid;
        n.imm = equeue_imm;
        if (cdb_valid && !n.rsv && n.rst == cdb_tag) begin
          n.rsv = 1'b1;
          n.rsd = cdb_data;
        end
        if (cdb_valid && !n.rtv && n.rtt == cdb_tag) begin
          n.rtv = 1'b1;
          n.rtd = cdb_data;
        end
        mq.push_back(n);
      end
    end
    m_run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk(input string nm);
    chk({nm, "_valid"}, issueint_valid, 1'b0);
    chk({nm, "_ready"}, equeueint_ready, 1'b0);
    chk({nm, "_fields"}, {issueint_opcode,
        issueint_rsdata, issueint_rtdata,
        issueint_imm, issueint_rdtag}, '0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    m_run  = 1'b0;
    idle();

    // en rsv rtv rst rtt rd rsd rtd cv ct cd gnt ev erd ers ert
    vt[0]  = '{0,0,0,0,0,0,0,0, 0,0,0, 0, 0,0,0,0};
    vt[1]  = '{1,1,1,0,0,6'h11,5,7, 0,0,0, 0, 0,0,0,0};
    vt[2]  = '{0,0,0,0,0,0,0,0, 0,0,0, 0, 1,6'h11,5,7};
    vt[3]  = '{0,0,0,0,0,0,0,0, 0,0,0, 1, 1,6'h11,5,7};
    vt[4]  = '{0,0,0,0,0,0,0,0, 0,0,0, 0, 0,0,0,0};
    vt[5]  = '{1,0,1,6'h03,0,6'h12,0,32'h22,
               0,0,0, 0, 0,0,0,0};
    vt[6]  = '{0,0,0,0,0,0,0,0,
               1,6'h03,32'hDEADBEEF, 0, 0,0,0,0};
    vt[7]  = '{0,0,0,0,0,0,0,0, 0,0,0,
               1, 1,6'h12,32'hDEADBEEF,32'h22};
    vt[8]  = '{1,1,0,0,6'h09,6'h13,1,0,
               1,6'h09,32'h1234, 0, 0,0,0,0};
    vt[9]  = '{0,0,0,0,0,0,0,0, 0,0,0,
               1, 1,6'h13,1,32'h1234};
    vt[10] = '{0,0,0,0,0,0,0,0, 0,0,0, 0, 0,0,0,0};

    repeat (2) @(posedge clk);
    #1;
    zero_chk("reset");
    reset = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) begin
      idle();
      equeueint_en     = vt[k].en;
      equeueint_opcode = 3'b010;
      equeue_imm       = 16'h00AA;
      equeue_rsvalid   = vt[k].rsv;
      equeue_rtvalid   = vt[k].rtv;
      equeue_rstag     = vt[k].rst;
      equeue_rttag     = vt[k].rtt;
      equeue_rdtag     = vt[k].rd;
      equeue_rsdata    = vt[k].rsd;
      equeue_rtdata    = vt[k].rtd;
      cdb_valid        = vt[k].cv;
      cdb_tag          = vt[k].ct;
      cdb_data         = vt[k].cd;
      issueint_grant   = vt[k].gnt;
      chk($sformatf("v%0d_valid", k),
          issueint_valid, vt[k].ev);
      chk($sformatf("v%0d_rdtag", k),
          issueint_rdtag, vt[k].erd);
      chk($sformatf("v%0d_rsdata", k),
          issueint_rsdata, vt[k].ers);
      chk($sformatf("v%0d_rtdata", k),
          issueint_rtdata, vt[k].ert);
      chk($sformatf("v%0d_ready", k),
          equeueint_ready, 1'b1);
      tick();
    end

    // oldest-ready select, full backpressure, order kept
    idle(); put(3'd1, 0, 1, 6'h20, 0, 6'h30, 0, 1); tick();
    idle(); put(3'd2, 1, 0, 0, 6'h21, 6'h31, 2, 0); tick();
    idle(); put(3'd3, 1, 1, 0, 0, 6'h32, 3, 4); tick();
    idle(); put(3'd4, 1, 1, 0, 0, 6'h33, 5, 6); tick();
    idle();
    chk("full_ready", equeueint_ready, 1'b0);
    chk("full_sel", issueint_rdtag, 6'h32);
    tick();
    issueint_grant = 1'b1;
    tick();
    idle();
    chk("after_gnt_ready", equeueint_ready, 1'b1);
    chk("after_gnt_sel", issueint_rdtag, 6'h33);
    issueint_grant = 1'b1;
    tick();
    idle(); bcast(6'h21, 32'hA1A1); tick();
    idle();
    chk("wake_e1", issueint_rdtag, 6'h31);
    bcast(6'h20, 32'hB2B2);
    tick();
    idle();
    chk("order_first", issueint_rdtag, 6'h30);
    chk("order_rs", issueint_rsdata, 32'hB2B2);
    issueint_grant = 1'b1;
    tick();
    idle();
    chk("order_second", issueint_rdtag, 6'h31);
    chk("order_rt", issueint_rtdata, 32'hA1A1);
    issueint_grant = 1'b1;
    tick();
    idle();
    chk("drained", issueint_valid, 1'b0);
    tick();

    // flush wins over grant, wakeup and full queue
    idle(); put(3'd5, 1, 1, 0, 0, 6'h01, 9, 9); tick();
    idle(); put(3'd5, 0, 1, 6'h2A, 0, 6'h02, 0, 0); tick();
    idle(); put(3'd5, 0, 1, 6'h2B, 0, 6'h03, 0, 0); tick();
    idle(); put(3'd5, 0, 1, 6'h2C, 0, 6'h04, 0, 0); tick();
    idle();
    chk("fl_full", equeueint_ready, 1'b0);
    issueint_grant = 1'b1;
    bcast(6'h2C, 32'h5555);
    flush = 1'b1;
    tick();
    idle();
    chk("fl_valid", issueint_valid, 1'b0);
    chk("fl_ready", equeueint_ready, 1'b1);
    tick();
    chk("fl_stay", issueint_valid, 1'b0);
    tick();

    // asynchronous reset with entries in flight
    idle(); put(3'd6, 1, 1, 0, 0, 6'h0A, 1, 2); tick();
    idle(); put(3'd6, 1, 1, 0, 0, 6'h0B, 3, 4); tick();
    idle(); put(3'd6, 1, 1, 0, 0, 6'h0C, 5, 6); tick();
    idle();
    issueint_grant = 1'b1;
    #3 reset = 1'b0;
    #1;
    zero_chk("mid_rst");
    mq.delete();
    m_run = 1'b0;
    @(posedge clk);
    #1;
    zero_chk("mid_rst_hold");
    reset = 1'b1;
    tick();
    tick();
    idle();
    tick();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      idle();
      if (m_ready() && $urandom_range(0, 2) != 0)
        put(3'($urandom),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            6'($urandom_range(0, 7)),
            6'($urandom_range(0, 7)),
            6'($urandom),
            $urandom, $urandom);
      if ($urandom_range(0, 1) != 0)
        bcast(6'($urandom_range(0, 7)), $urandom);
      issueint_grant = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
